pattern_scheduler: RTL and testbench
====================================

Name: pattern_scheduler

Overview:
- Frame-synchronous scheduler that shares the single RGB output between NUM_SRC test-pattern sources. Sources include the SMPTE bars, a grid and solid fills.
- The active source advances on a debounced button press or on an auto-cycle frame timer. Switches take effect only at frame boundaries, with one fully blanked frame between patterns.
- Sits between hvsync_generator plus the pattern generators and the video output pins. Registers rgb, and delays hsync/vsync by the same one cycle so they stay aligned.

Parameters:
- NUM_SRC, 4, number of pattern sources, 2..8.
- SEL_W, 2, select width; must equal ceil(log2(NUM_SRC)).
- AUTO_FRAMES, 120, frames per pattern in auto mode, 1..255.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- hpos  in  9  horizontal beam position from hvsync_generator.
- vpos  in  9  vertical beam position from hvsync_generator.
- display_on  in  1  visible-area flag from hvsync_generator.
- hsync_in  in  1  hsync from hvsync_generator.
- vsync_in  in  1  vsync from hvsync_generator.
- src_rgb  in  3*NUM_SRC  source k drives bits [3k+2:3k].
- btn_next  in  1  asynchronous pushbutton, active-high.
- auto_en  in  1  auto-cycle enable; treated as quasi-static.
- hsync  out  1  hsync_in delayed 1 clk.
- vsync  out  1  vsync_in delayed 1 clk.
- rgb  out  3  selected and gated pixel, registered.
- sel  out  SEL_W  index of the source currently shown.
- blanking  out  1  high for the whole of the blank transition frame.

Behaviour:
- Reset values: rgb=0, hsync=0, vsync=0, sel=0, blanking=0, state=SHOW, frame_cnt=0, button sampler=0. All flops use the asynchronous reset.
- Frame tick: frame_tick = (hpos==0 && vpos==0). This is a one-cycle pulse per frame, computed combinationally from the inputs.
- Button path:
  - 2-flop synchroniser on btn_next.
  - The synchronised level is re-sampled only on frame_tick, which debounces at frame rate.
  - btn_evt = sampled level rose between two consecutive frame_ticks, i.e. new=1 and old=0.
  - A held button produces exactly one event.
- Auto timer (8-bit frame_cnt):
  - auto_en=0: frame_cnt held at 0.
  - Otherwise, on frame_tick in SHOW: if frame_cnt==AUTO_FRAMES-1, assert auto_evt and reset frame_cnt to 0; else increment.
  - frame_cnt also clears to 0 on any switch.
- req = frame_tick && (btn_evt || auto_evt). Simultaneous button and auto events produce a single advance.
- FSM (2 states, encodings in shared include):
  - SHOW: on req -> BLANK and set blanking=1. Both take effect at the same edge as the frame_tick, so the frame starting now is blank.
  - BLANK: requests are ignored and not queued. On the next frame_tick -> SHOW, clear blanking, advance sel, and clear frame_cnt.
  - sel advances as sel+1 when sel<NUM_SRC-1, else 0 (wrap).
- Datapath: the rgb register loads src_rgb[sel] when display_on=1 and state==SHOW, else 0. Latency is 1 clk from hpos/vpos/display_on.
- hsync and vsync are each delayed by one flop, matching the rgb latency.
- Reset mid-BLANK returns to SHOW with sel=0 on the next cycle after reset deasserts. No partial frame state is retained.
- src_rgb changes are not sampled specially; a source is responsible for its own frame consistency.

Decomposition:
- Shared include pattern_defs.vh holds:
  - state encodings ST_SHOW=1'b0 and ST_BLANK=1'b1;
  - default NUM_SRC;
  - source index constants SRC_BARS=0, SRC_GRID=1, SRC_SOLID=2, SRC_NOISE=3.
- One sub-module, frame_btn_edge (ports: clk, reset, btn_async, frame_tick, evt), containing the synchroniser, the frame-rate sampler and the edge detect.

Test Plan:
- Reset asserted mid-frame, then released: rgb=0, sel=0, state=SHOW. At hpos=5 visible with src_rgb[2:0]=3'b110, rgb=3'b110 one clk later. hsync and vsync are delayed exactly 1 clk.
- auto_en=1, AUTO_FRAMES=3, button low: sel sequence per frame is 0,0,0,blank,1,1,1,blank,2,... wrapping 3 to 0. blanking high for exactly one frame each time. rgb=0 throughout each blank frame.
- btn_next pulse 10 clks wide mid-frame, auto_en=0: one advance only. Blank starts at the next frame_tick, and sel=1 the frame after. A button held for 5 frames still gives one advance.
- Button event and auto expiry on the same frame_tick: sel advances by 1, not 2.
- Button pressed during BLANK frame and released before the next tick: ignored, and sel advances by exactly 1. Async reset asserted during BLANK: sel=0, blanking=0 immediately.
- display_on=0 with src_rgb all-ones: rgb stays 0. Toggle auto_en 1 to 0 to 1 mid-count: frame_cnt restarts, so the next switch is AUTO_FRAMES frames after re-enable.

Source files
------------

// File: rtl/pattern_scheduler_pkg.sv
// rtl/pattern_scheduler_pkg.sv - shared state encodings and source indices for the pattern scheduler
package pattern_scheduler_pkg;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    localparam int DEFAULT_NUM_SRC = 4;

    localparam int SRC_BARS  = 0;
    localparam int SRC_GRID  = 1;
    localparam int SRC_SOLID = 2;
    localparam int SRC_NOISE = 3;

endpackage

// File: rtl/pattern_scheduler_frame_btn_edge.sv
// rtl/pattern_scheduler_frame_btn_edge.sv - button synchroniser, frame-rate sampler and rising-edge event
module frame_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_async,
    input  logic frame_tick,
    output logic evt
);

    logic sync1_q;
    logic sync2_q;
    logic samp_q;

    // Sampling only once per frame is what debounces the button; a level held
    // across several frames compares equal to itself and yields no new edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            samp_q  <= 1'b0;
        end else begin
            sync1_q <= btn_async;
            sync2_q <= sync1_q;
            if (frame_tick) begin
                samp_q <= sync2_q;
            end
        end
    end

    assign evt = frame_tick & sync2_q & ~samp_q;

endmodule

// File: rtl/pattern_scheduler.sv
// rtl/pattern_scheduler.sv - frame-synchronous selector of test-pattern sources with a blank frame between switches
module pattern_scheduler
    import pattern_scheduler_pkg::*;
#(
    parameter int NUM_SRC     = DEFAULT_NUM_SRC,
    parameter int SEL_W       = 2,
    parameter int AUTO_FRAMES = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8:0]           hpos,
    input  logic [8:0]           vpos,
    input  logic                 display_on,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic [3*NUM_SRC-1:0] src_rgb,
    input  logic                 btn_next,
    input  logic                 auto_en,
    output logic                 hsync,
    output logic                 vsync,
    output logic [2:0]           rgb,
    output logic [SEL_W-1:0]     sel,
    output logic                 blanking
);

    localparam logic [7:0]       AUTO_LAST = 8'(AUTO_FRAMES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_SRC - 1);

    logic frame_tick;
    logic btn_evt;
    logic auto_evt;
    logic req;
    logic [2:0] src_pix;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             blank_q, blank_d;
    logic [2:0]       rgb_q, rgb_d;
    logic             hs_q, vs_q;

    assign frame_tick = (hpos == 9'd0) && (vpos == 9'd0);

    frame_btn_edge u_btn (
        .clk        (clk),
        .reset      (reset),
        .btn_async  (btn_next),
        .frame_tick (frame_tick),
        .evt        (btn_evt)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        blank_d  = blank_q;
        auto_evt = 1'b0;

        if (!auto_en) begin
            cnt_d = 8'd0;
        end else if (frame_tick && state_q == ST_SHOW) begin
            if (cnt_q == AUTO_LAST) begin
                auto_evt = 1'b1;
                cnt_d    = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        // Button and auto expiry on the same tick collapse into one request.
        req = frame_tick && (btn_evt || auto_evt);

        unique case (state_q)
            ST_SHOW: begin
                if (req) begin
                    state_d = ST_BLANK;
                    blank_d = 1'b1;
                end
            end
            ST_BLANK: begin
                if (frame_tick) begin
                    state_d = ST_SHOW;
                    blank_d = 1'b0;
                    cnt_d   = 8'd0;
                    sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SHOW;
                blank_d = 1'b0;
            end
        endcase

        // Gate with the next state so the pixel sampled on the tick already
        // belongs to the new frame's mode and source.
        src_pix = src_rgb[3*int'(sel_d) +: 3];
        rgb_d   = (display_on && state_d == ST_SHOW) ? src_pix : 3'b000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SHOW;
            sel_q   <= '0;
            cnt_q   <= 8'd0;
            blank_q <= 1'b0;
            rgb_q   <= 3'b000;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
            hs_q    <= hsync_in;
            vs_q    <= vsync_in;
        end
    end

    assign rgb      = rgb_q;
    assign hsync    = hs_q;
    assign vsync    = vs_q;
    assign sel      = sel_q;
    assign blanking = blank_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// tb/tb_pattern_scheduler.sv - directed self-checking bench for pattern_scheduler on a 16x8 miniature raster
module tb_pattern_scheduler;

    localparam int H = 16;
    localparam int V = 8;
    localparam logic [11:0] SRC_PAT = {3'b111, 3'b101, 3'b011, 3'b110};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  hpos = '0;
    logic [8:0]  vpos = '0;
    logic        display_on = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [11:0] src_rgb = SRC_PAT;
    logic        btn_next = 1'b0;
    logic        auto_en = 1'b0;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic [1:0]  sel;
    logic        blanking;

    int n_tests = 0;
    int n_fail  = 0;
    int hc = 7;
    int vc = 3;

    pattern_scheduler #(
        .NUM_SRC     (4),
        .SEL_W       (2),
        .AUTO_FRAMES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .src_rgb    (src_rgb),
        .btn_next   (btn_next),
        .auto_en    (auto_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .sel        (sel),
        .blanking   (blanking)
    );

    always #5 clk = ~clk;

    task automatic drive_beam();
        hpos       = 9'(hc);
        vpos       = 9'(vc);
        display_on = (hc < 12) && (vc < 6);
        hsync_in   = (hc >= 13) && (hc < 15);
        vsync_in   = (vc == 7);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        hc = hc + 1;
        if (hc == H) begin
            hc = 0;
            vc = (vc + 1) % V;
        end
        drive_beam();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int h, input int v);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * H * V; i++) begin
            if (hc == h && vc == v) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $error("FAIL run_to_timeout: beam at %0d,%0d required %0d,%0d", hc, vc, h, v);
        end
    endtask

    task automatic next_tick();
        run_to(0, 0);
        step();
    endtask

    task automatic check_pix(input string tag, input logic [2:0] exp);
        run_to(5, 1);
        step();
        check(tag, 8'(rgb), 8'(exp));
    endtask

    function automatic logic [2:0] src_of(input int s);
        logic [11:0] p;
        p = SRC_PAT;
        return p[3*s +: 3];
    endfunction

    int exp_sel[16]   = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    bit exp_blank[16] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};

    initial begin
        drive_beam();
        // reset held mid-frame
        repeat (3) step();
        check("rst_rgb", 8'(rgb), 8'd0);
        check("rst_sel", 8'(sel), 8'd0);
        check("rst_blanking", 8'(blanking), 8'd0);
        check("rst_hsync", 8'(hsync), 8'd0);
        check("rst_vsync", 8'(vsync), 8'd0);
        reset = 1'b0;
        step();
        check("post_rst_sel", 8'(sel), 8'd0);
        check("post_rst_blanking", 8'(blanking), 8'd0);

        // sync delay
        run_to(13, 2);
        check("hsync_before", 8'(hsync), 8'd0);
        step();
        check("hsync_delayed", 8'(hsync), 8'd1);
        step();
        step();
        check("hsync_fall", 8'(hsync), 8'd0);
        run_to(0, 7);
        check("vsync_before", 8'(vsync), 8'd0);
        step();
        check("vsync_delayed", 8'(vsync), 8'd1);
        run_to(0, 0);
        step();
        check("vsync_fall", 8'(vsync), 8'd0);

        // datapath and display gating
        check_pix("pix_src0", 3'b110);
        run_to(13, 1);
        step();
        check("pix_hblank", 8'(rgb), 8'd0);
        src_rgb = '1;
        run_to(3, 7);
        step();
        check("pix_off_allones", 8'(rgb), 8'd0);
        run_to(5, 2);
        step();
        check("pix_on_allones", 8'(rgb), 8'd7);
        run_to(14, 2);
        step();
        check("pix_off_allones2", 8'(rgb), 8'd0);
        src_rgb = SRC_PAT;

        // 10-clock button pulse straddling the frame tick
        run_to(8, 7);
        btn_next = 1'b1;
        repeat (10) step();
        btn_next = 1'b0;
        check("btn_blank_start", 8'(blanking), 8'd1);
        check("btn_blank_sel", 8'(sel), 8'd0);
        check_pix("btn_blank_pix", 3'b000);
        next_tick();
        check("btn_sel1", 8'(sel), 8'd1);
        check("btn_show", 8'(blanking), 8'd0);
        check_pix("btn_pix_src1", 3'b011);

        // button held for 5 frames
        run_to(8, 7);
        btn_next = 1'b1;
        next_tick();
        check("hold_blank", 8'(blanking), 8'd1);
        repeat (4) next_tick();
        btn_next = 1'b0;
        next_tick();
        next_tick();
        check("hold_sel2", 8'(sel), 8'd2);
        check("hold_show", 8'(blanking), 8'd0);

        // press during BLANK, released before the next tick
        run_to(8, 7);
        btn_next = 1'b1;
        next_tick();
        btn_next = 1'b0;
        check("inblank_blank", 8'(blanking), 8'd1);
        run_to(5, 3);
        btn_next = 1'b1;
        repeat (10) step();
        btn_next = 1'b0;
        next_tick();
        check("inblank_sel3", 8'(sel), 8'd3);
        check("inblank_show", 8'(blanking), 8'd0);
        next_tick();
        check("inblank_sel3_again", 8'(sel), 8'd3);
        check("inblank_no_requeue", 8'(blanking), 8'd0);

        // async reset while blanking
        run_to(8, 7);
        btn_next = 1'b1;
        next_tick();
        btn_next = 1'b0;
        check("rstblank_pre", 8'(blanking), 8'd1);
        run_to(6, 2);
        #2;
        reset = 1'b1;
        #1;
        check("rstblank_sel", 8'(sel), 8'd0);
        check("rstblank_blanking", 8'(blanking), 8'd0);
        check("rstblank_rgb", 8'(rgb), 8'd0);
        step();
        reset = 1'b0;
        next_tick();
        check("rstblank_after_sel", 8'(sel), 8'd0);
        check("rstblank_after_show", 8'(blanking), 8'd0);
        check_pix("rstblank_after_pix", 3'b110);

        // auto cycling with AUTO_FRAMES=3, including wrap 3 -> 0
        auto_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            next_tick();
            check($sformatf("auto_sel_%0d", k), 8'(sel), 8'(exp_sel[k]));
            check($sformatf("auto_blank_%0d", k), 8'(blanking), 8'(exp_blank[k]));
            check_pix($sformatf("auto_pix_%0d", k),
                      exp_blank[k] ? 3'b000 : src_of(exp_sel[k]));
        end

        // auto_en toggled mid-count restarts the count
        next_tick();
        next_tick();
        run_to(4, 4);
        auto_en = 1'b0;
        repeat (3) step();
        auto_en = 1'b1;
        next_tick();
        check("toggle_t1", 8'(blanking), 8'd0);
        next_tick();
        check("toggle_t2", 8'(blanking), 8'd0);
        next_tick();
        check("toggle_t3_blank", 8'(blanking), 8'd1);
        next_tick();
        check("toggle_sel1", 8'(sel), 8'd1);

        // button and auto expiry on the same tick
        next_tick();
        next_tick();
        run_to(8, 7);
        btn_next = 1'b1;
        next_tick();
        btn_next = 1'b0;
        check("both_blank", 8'(blanking), 8'd1);
        check("both_sel_hold", 8'(sel), 8'd1);
        next_tick();
        check("both_sel2", 8'(sel), 8'd2);
        check("both_show", 8'(blanking), 8'd0);
        next_tick();
        check("both_sel2_stable", 8'(sel), 8'd2);
        check("both_show_stable", 8'(blanking), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
